// File: rtl/fetch_ctrl_r32i_if.sv
// Fetch-stage bus: instruction-memory handshake, decode handshake, redirect and status.
// The fetch controller uses the master modport; the memory/decode side uses slave.
interface fetch_ctrl_r32i_if #(
  parameter int dataW = 32
);
  logic             imem_req;
  logic [dataW-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [dataW-1:0] instr_pc;
  logic             instr_ready;
  logic             redirect;
  logic [dataW-1:0] redirect_base;
  logic [dataW-1:0] redirect_offset;
  logic             fault;
  logic [31:0]      fetch_cnt;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fault, fetch_cnt,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
           redirect, redirect_base, redirect_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fault, fetch_cnt,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
           redirect, redirect_base, redirect_offset
  );
endinterface

// File: rtl/fetch_ctrl_r32i.sv
// RV32I instruction-fetch sequencer: owns the PC and keeps one fetch in flight at a time.
// Registers each fetched word with its PC and halts on a misaligned redirect target.
module fetch_ctrl_r32i #(
  parameter int               dataW      = 32,
  parameter logic [dataW-1:0] RESET_ADDR = '0
) (
  input  logic               clock,
  input  logic               reset,
  fetch_ctrl_r32i_if.master  bus
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP,
    S_HALT
  } state_t;

  state_t           state, state_n;
  logic [dataW-1:0] pc, pc_n;
  logic [dataW-1:0] target;
  logic             valid_q, valid_n;
  logic [31:0]      instr_q, instr_n;
  logic [dataW-1:0] ipc_q, ipc_n;
  logic [31:0]      cnt_q, cnt_n;

  // Relative jump target; the add wraps modulo 2^dataW by construction.
  assign target = bus.redirect_base + bus.redirect_offset;

  // NOTE: registers use non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_REQ;
      pc      <= RESET_ADDR;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
      cnt_q   <= cnt_n;
    end
  end

  // NOTE: every variable gets its hold value first, so no branch can infer a latch.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = valid_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    cnt_n   = cnt_q;

    if (bus.redirect && state != S_HALT) begin
      valid_n = 1'b0;
      if (target[1:0] != 2'b00) begin
        state_n = S_HALT;
      end else begin
        pc_n = target;
        // A response already granted at the old PC must be drained before refetching.
        case (state)
          S_REQ:          state_n = bus.imem_gnt ? S_DROP : S_REQ;
          S_WAIT, S_DROP: state_n = bus.imem_rvalid ? S_REQ : S_DROP;
          default:        state_n = S_REQ;
        endcase
      end
    end else begin
      case (state)
        S_REQ: begin
          if (bus.imem_gnt) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            instr_n = bus.imem_rdata;
            ipc_n   = pc;
            valid_n = 1'b1;
            state_n = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            valid_n = 1'b0;
            pc_n    = pc + dataW'(4);
            cnt_n   = cnt_q + 32'd1;
            state_n = S_REQ;
          end
        end
        S_DROP: begin
          if (bus.imem_rvalid) state_n = S_REQ;
        end
        default: state_n = S_HALT;
      endcase
    end
  end

  assign bus.imem_req    = (state == S_REQ);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.fault       = (state == S_HALT);
  assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl_r32i.sv
// Self-checking bench for fetch_ctrl_r32i: directed table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_fetch_ctrl_r32i;

  logic clock;
  logic reset;

  fetch_ctrl_r32i_if #(.dataW(32)) bus ();

  fetch_ctrl_r32i #(.dataW(32), .RESET_ADDR(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: fetch described by flags (halted / holding / awaiting response).
  logic [31:0] m_pc, m_cnt, m_instr, m_ipc;
  logic        m_valid, m_out, m_squash, m_halt;

  typedef struct {
    logic        gnt, rvalid, ready;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr, ipc, cnt;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(input logic g, rv, rd, input logic [31:0] dat,
                              input logic req, input logic [31:0] addr, input logic v,
                              input logic [31:0] ins, ipc, cnt);
    vec_t t;
    t.gnt = g; t.rvalid = rv; t.ready = rd; t.rdata = dat;
    t.req = req; t.addr = addr; t.valid = v; t.instr = ins; t.ipc = ipc; t.cnt = cnt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_cnt = '0; m_instr = '0; m_ipc = '0;
    m_valid = 1'b0; m_out = 1'b0; m_squash = 1'b0; m_halt = 1'b0;
  endtask

  function automatic logic model_req();
    return !m_halt && !m_valid && !m_out;
  endfunction

  task automatic model_next(input logic g, rv, rd, rdr, input logic [31:0] b, o, dat);
    logic [31:0] t;
    logic        req_now;
    req_now = model_req();
    t = b + o;
    if (m_halt) begin
      // halted: everything ignored until reset
    end else if (rdr) begin
      m_valid = 1'b0;
      if (t[1:0] != 2'b00) begin
        m_halt = 1'b1;
      end else begin
        m_pc     = t;
        m_out    = (m_out && !rv) || (req_now && g);
        m_squash = m_out;
      end
    end else if (req_now && g) begin
      m_out    = 1'b1;
      m_squash = 1'b0;
    end else if (m_out && rv) begin
      m_out = 1'b0;
      if (!m_squash) begin
        m_valid = 1'b1;
        m_instr = dat;
        m_ipc   = m_pc;
      end
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
  endtask

  task automatic compare_model();
    check("mdl_req",   32'(bus.imem_req),    32'(model_req()));
    check("mdl_addr",  bus.imem_addr,        m_pc);
    check("mdl_valid", 32'(bus.instr_valid), 32'(m_valid));
    check("mdl_instr", bus.instr,            m_instr);
    check("mdl_ipc",   bus.instr_pc,         m_ipc);
    check("mdl_fault", 32'(bus.fault),       32'(m_halt));
    check("mdl_cnt",   bus.fetch_cnt,        m_cnt);
  endtask

  // Called at a falling edge: drive, advance one clock, compare at the next falling edge.
  task automatic step(input logic g, rv, rd, rdr, input logic [31:0] b, o, dat);
    bus.imem_gnt        = g;
    bus.imem_rvalid     = rv;
    bus.instr_ready     = rd;
    bus.redirect        = rdr;
    bus.redirect_base   = b;
    bus.redirect_offset = o;
    bus.imem_rdata      = dat;
    model_next(g, rv, rd, rdr, b, o, dat);
    @(posedge clock);
    @(negedge clock);
    compare_model();
  endtask

  task automatic idle_inputs();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.instr_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_base = '0; bus.redirect_offset = '0;
    bus.imem_rdata = '0;
  endtask

  // Asserted between clock edges so the reset values prove the reset is asynchronous.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_req",   32'(bus.imem_req),    32'd1);
    check("rst_addr",  bus.imem_addr,        32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr,            32'h0);
    check("rst_fault", 32'(bus.fault),       32'd0);
    check("rst_cnt",   bus.fetch_cnt,        32'd0);
    #2;
    reset = 1'b0;
    @(negedge clock);
    compare_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 32'h0,        32'h0, 32'd0);
    tbl[1] = mk(1'b0, 1'b1, 1'b0, 32'h00000013, 1'b0, 32'h0, 1'b1, 32'h00000013, 32'h0, 32'd0);
    tbl[2] = mk(1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h4, 1'b0, 32'h00000013, 32'h0, 32'd1);
    tbl[3] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h4, 1'b0, 32'h00000013, 32'h0, 32'd1);
    tbl[4] = mk(1'b0, 1'b1, 1'b0, 32'h00100093, 1'b0, 32'h4, 1'b1, 32'h00100093, 32'h4, 32'd1);
    tbl[5] = mk(1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h8, 1'b0, 32'h00100093, 32'h4, 32'd2);
    tbl[6] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h8, 1'b0, 32'h00100093, 32'h4, 32'd2);
    tbl[7] = mk(1'b0, 1'b1, 1'b0, 32'h002081b3, 1'b0, 32'h8, 1'b1, 32'h002081b3, 32'h8, 32'd2);
    tbl[8] = mk(1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'hC, 1'b0, 32'h002081b3, 32'h8, 32'd3);

    repeat (2) @(negedge clock);
    do_reset();

    // Zero-wait memory, decode always ready.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].gnt, tbl[i].rvalid, tbl[i].ready, 1'b0, 32'h0, 32'h0, tbl[i].rdata);
      check($sformatf("tbl%0d_req", i),   32'(bus.imem_req),    32'(tbl[i].req));
      check($sformatf("tbl%0d_addr", i),  bus.imem_addr,        tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_instr", i), bus.instr,            tbl[i].instr);
      check($sformatf("tbl%0d_ipc", i),   bus.instr_pc,         tbl[i].ipc);
      check($sformatf("tbl%0d_cnt", i),   bus.fetch_cnt,        tbl[i].cnt);
    end

    // Decode stalls in HOLD; gnt/rvalid noise must be ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA5A50013);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h11111111 * (i + 1));
      check("stall_instr", bus.instr,            32'hA5A50013);
      check("stall_ipc",   bus.instr_pc,         32'hC);
      check("stall_req",   32'(bus.imem_req),    32'd0);
      check("stall_addr",  bus.imem_addr,        32'hC);
      check("stall_valid", 32'(bus.instr_valid), 32'd1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    check("stall_next_req",  32'(bus.imem_req), 32'd1);
    check("stall_next_addr", bus.imem_addr,     32'h10);

    // Redirect in WAIT: in-flight word is dropped, refetch at 0x10-8.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFF8, 32'h0);
    check("rdw_addr", bus.imem_addr,     32'h8);
    check("rdw_req",  32'(bus.imem_req), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
    check("rdw_drop_valid", 32'(bus.instr_valid), 32'd0);
    check("rdw_drop_req",   32'(bus.imem_req),    32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00000513);
    check("rdw_instr", bus.instr,    32'h00000513);
    check("rdw_ipc",   bus.instr_pc, 32'h8);

    // Redirect together with ready in HOLD: squashed, not counted.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h100, 32'h0);
    check("rdh_cnt",   bus.fetch_cnt,        32'd4);
    check("rdh_addr",  bus.imem_addr,        32'h120);
    check("rdh_valid", 32'(bus.instr_valid), 32'd0);

    // Wrapping target, then PC+4 wraps to zero.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF0, 32'hC, 32'h0);
    check("wrap_addr", bus.imem_addr, 32'hFFFFFFFC);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00008067);
    check("wrap_ipc", bus.instr_pc, 32'hFFFFFFFC);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    check("wrap_pc4", bus.imem_addr, 32'h0);
    check("wrap_cnt", bus.fetch_cnt, 32'd5);

    // Misaligned redirect halts fetch until reset.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'h2, 32'h0);
    check("mis_fault", 32'(bus.fault),    32'd1);
    check("mis_req",   32'(bus.imem_req), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 32'h100, 32'h0, $urandom);
      check("halt_req",   32'(bus.imem_req),    32'd0);
      check("halt_valid", 32'(bus.instr_valid), 32'd0);
      check("halt_addr",  bus.imem_addr,        32'h0);
    end
    do_reset();

    // Grant withheld, then redirect re-aims the pending request.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      check("nogt_req", 32'(bus.imem_req), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
    check("nogt_rd_req",  32'(bus.imem_req), 32'd1);
    check("nogt_rd_addr", bus.imem_addr,     32'h40);

    // Randomized traffic against the reference model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] b, o;
      logic        rdr;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        rdr = ($urandom_range(0, 11) == 0);
        b   = $urandom & 32'hFFFFFFFC;
        if ($urandom_range(0, 15) == 0) o = $urandom;
        else o = 32'($signed($urandom_range(0, 512)) - 256) & 32'hFFFFFFFC;
        if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFF0 + ($urandom_range(0, 3) * 4);
        step(1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 6), rdr, b, o, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
